// File: rtl/probe_pkt_arbiter.sv
// Packet-granular two-input round-robin arbiter.
// Each input is buffered in a small fall-through FIFO. The output is held by one
// input for a whole packet, so words from different packets never interleave.

// Fall-through FIFO: the head word is visible on dout whenever empty is low.
module fallthrough_small_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] ONE = 1;
  // One slot of headroom: a writer that sees rdy high can always land one more word.
  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;

  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_LEVEL);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// state     | meaning
// IDLE      | no packet owns the output; pick the next input (one bubble cycle)
// SEND_HDR  | forwarding header words (ctrl != 0) of the granted input
// SEND_DATA | forwarding data words; the next ctrl != 0 word ends the packet
module probe_pkt_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  grant,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
);
  localparam int W = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_DATA} state_t;

  state_t         state;
  logic           sel;
  logic           last_grant;
  logic [W-1:0]   head0, head1, head;
  logic           empty0, empty1, nf0, nf1;
  logic           xfer;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  fallthrough_small_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo0 (
    .clk(clk), .reset(reset), .din({in0_ctrl, in0_data}), .wr_en(in0_wr),
    .rd_en(xfer && !sel), .dout(head0), .empty(empty0), .nearly_full(nf0)
  );

  fallthrough_small_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo1 (
    .clk(clk), .reset(reset), .din({in1_ctrl, in1_data}), .wr_en(in1_wr),
    .rd_en(xfer && sel), .dout(head1), .empty(empty1), .nearly_full(nf1)
  );

  assign in0_rdy   = !nf0;
  assign in1_rdy   = !nf1;
  assign head      = sel ? head1 : head0;
  assign head_ctrl = head[W-1 -: CTRL_WIDTH];
  assign out_ctrl  = head_ctrl;
  assign out_data  = head[DATA_WIDTH-1:0];
  assign xfer      = (state != IDLE) && !(sel ? empty1 : empty0) && out_rdy;
  assign out_wr    = xfer;
  assign grant     = sel;

  // Packet-level arbitration FSM with per-input packet counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty0 && !empty1) begin
            sel   <= !last_grant;
            state <= SEND_HDR;
          end else if (!empty0) begin
            sel   <= 1'b0;
            state <= SEND_HDR;
          end else if (!empty1) begin
            sel   <= 1'b1;
            state <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (xfer && head_ctrl == '0) state <= SEND_DATA;
        end
        SEND_DATA: begin
          if (xfer && head_ctrl != '0) begin
            state      <= IDLE;
            last_grant <= sel;
            if (sel) pkt_cnt1 <= pkt_cnt1 + 32'd1;
            else     pkt_cnt0 <= pkt_cnt0 + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_probe_pkt_arbiter.sv
// Bench for probe_pkt_arbiter: per-input scoreboards of written words, an
// expected-source queue for packet order, a packet-vector table and a few
// hand-written multi-cycle sequences.
module tb_probe_pkt_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in0_data = '0, in1_data = '0;
  logic [7:0]  in0_ctrl = '0, in1_ctrl = '0;
  logic        in0_wr = 1'b0, in1_wr = 1'b0;
  logic        in0_rdy, in1_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        grant;
  logic [31:0] pkt_cnt0, pkt_cnt1;

  probe_pkt_arbiter dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_ctrl(in0_ctrl), .in0_wr(in0_wr), .in0_rdy(in0_rdy),
    .in1_data(in1_data), .in1_ctrl(in1_ctrl), .in1_wr(in1_wr), .in1_rdy(in1_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [71:0] sbq0[$];
  logic [71:0] sbq1[$];
  int          src_q[$];

  int  cyc = 0;
  bit  in_pkt = 0, seen_data = 0, have_last = 0, chk_bubble = 0;
  int  cur_src = 0, first_cyc = 0, last_cyc = 0, pkts_done = 0;

  typedef struct {
    int          src;
    int          nhdr;
    int          ndata;
    logic [7:0]  lastc;
    bit          tog;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eg;
  } vec_t;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every forwarded word is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      in_pkt    = 0;
      seen_data = 0;
    end else if (out_wr) begin
      logic [71:0] exp_w;
      if (!in_pkt) begin
        if (src_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pkt: got word %h expected no output", {out_ctrl, out_data});
          cur_src = grant;
        end else begin
          cur_src = src_q.pop_front();
        end
        in_pkt    = 1;
        seen_data = 0;
        first_cyc = cyc;
        if (chk_bubble && have_last) chk("bubble_gap", 72'(cyc - last_cyc), 72'd2);
      end
      chk("grant_in_pkt", 72'(grant), 72'(cur_src));
      chk("wr_needs_rdy", 72'(out_rdy), 72'd1);
      if (cur_src == 0 ? sbq0.size() == 0 : sbq1.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_word: got %h expected nothing from input %0d", {out_ctrl, out_data}, cur_src);
      end else begin
        exp_w = (cur_src == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk("out_word", {out_ctrl, out_data}, exp_w);
      end
      if (out_ctrl == 8'h00) seen_data = 1;
      else if (seen_data) begin
        in_pkt    = 0;
        last_cyc  = cyc;
        have_last = 1;
        pkts_done++;
      end
    end
  end

  // Write one word into input p, waiting (bounded) for its rdy.
  task automatic send_word(input int p, input logic [7:0] c, input logic [63:0] d);
    int n = 0;
    while (((p == 0) ? in0_rdy : in1_rdy) !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL feed_timeout: input %0d rdy stuck low, required 1", p);
      return;
    end
    if (p == 0) begin
      in0_ctrl = c; in0_data = d; in0_wr = 1'b1; sbq0.push_back({c, d});
    end else begin
      in1_ctrl = c; in1_data = d; in1_wr = 1'b1; sbq1.push_back({c, d});
    end
    @(posedge clk); #1;
    if (p == 0) in0_wr = 1'b0; else in1_wr = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int nhdr, input int ndata, input logic [7:0] lastc);
    for (int i = 0; i < nhdr; i++) send_word(p, 8'hFF, {$urandom, $urandom});
    for (int i = 0; i < ndata; i++) send_word(p, 8'h00, {$urandom, $urandom});
    send_word(p, lastc, {$urandom, $urandom});
  endtask

  task automatic toggler(input int target);
    int n = 0;
    while (pkts_done < target && n < 400) begin
      @(posedge clk); #1;
      out_rdy = ~out_rdy;
      n++;
    end
    out_rdy = 1'b1;
  endtask

  // Wait for the counters to reach their expected values, then check idle state.
  task automatic wait_cnt(input string name, input logic [31:0] e0, input logic [31:0] e1);
    int n = 0;
    while (!(pkt_cnt0 == e0 && pkt_cnt1 == e1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_cnt0"}, 72'(pkt_cnt0), 72'(e0));
    chk({name, "_cnt1"}, 72'(pkt_cnt1), 72'(e1));
    @(negedge clk);
    chk({name, "_drained"}, 72'(sbq0.size() + sbq1.size() + src_q.size()), 72'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq0.delete(); sbq1.delete(); src_q.delete();
    have_last = 0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{src: 0, nhdr: 1, ndata: 3, lastc: 8'h80, tog: 1'b0, e0: 32'd1, e1: 32'd0, eg: 1'b0};
    vecs[1] = '{src: 1, nhdr: 2, ndata: 2, lastc: 8'h0F, tog: 1'b1, e0: 32'd1, e1: 32'd1, eg: 1'b1};
    vecs[2] = '{src: 0, nhdr: 1, ndata: 5, lastc: 8'h03, tog: 1'b1, e0: 32'd2, e1: 32'd1, eg: 1'b0};
    vecs[3] = '{src: 1, nhdr: 1, ndata: 1, lastc: 8'hFF, tog: 1'b0, e0: 32'd2, e1: 32'd2, eg: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_wr", 72'(out_wr), 72'd0);
    chk("rst_in0_rdy", 72'(in0_rdy), 72'd1);
    chk("rst_in1_rdy", 72'(in1_rdy), 72'd1);
    chk("rst_grant", 72'(grant), 72'd0);
    chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 72'd0);
    @(posedge clk); #1;

    // Packet vectors
    for (int v = 0; v < 4; v++) begin
      int target;
      target = pkts_done + 1;
      src_q.push_back(vecs[v].src);
      fork
        send_pkt(vecs[v].src, vecs[v].nhdr, vecs[v].ndata, vecs[v].lastc);
        if (vecs[v].tog) toggler(target);
      join
      wait_cnt($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1);
      chk($sformatf("vec%0d_grant", v), 72'(grant), 72'(vecs[v].eg));
      if (!vecs[v].tog)
        chk($sformatf("vec%0d_back2back", v), 72'(last_cyc - first_cyc), 72'(vecs[v].nhdr + vecs[v].ndata));
      @(posedge clk); #1;
    end

    // Both inputs loaded with three packets from reset: strict alternation, input 0 first
    do_reset();
    for (int i = 0; i < 3; i++) begin src_q.push_back(0); src_q.push_back(1); end
    chk_bubble = 1;
    fork
      begin send_pkt(0, 1, 2, 8'h80); send_pkt(0, 2, 1, 8'h01); send_pkt(0, 1, 3, 8'h0F); end
      begin send_pkt(1, 1, 1, 8'hFF); send_pkt(1, 1, 4, 8'h07); send_pkt(1, 2, 2, 8'h3F); end
    join
    wait_cnt("rr3", 32'd3, 32'd3);
    chk_bubble = 0;

    // Input 1 stalls mid-data while input 0 has a packet waiting
    do_reset();
    src_q.push_back(1); src_q.push_back(0);
    send_word(1, 8'hFF, 64'h1111_0000_0000_0001);
    fork
      send_pkt(0, 1, 2, 8'h01);
      begin
        int n = 0;
        send_word(1, 8'h00, 64'h1111_0000_0000_0002);
        while (sbq1.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("stall_wr0_a", 72'(out_wr), 72'd0);
        chk("stall_grant_a", 72'(grant), 72'd1);
        @(negedge clk);
        chk("stall_wr0_b", 72'(out_wr), 72'd0);
        chk("stall_grant_b", 72'(grant), 72'd1);
        @(posedge clk); #1;
        send_word(1, 8'h00, 64'h1111_0000_0000_0003);
        send_word(1, 8'h0F, 64'h1111_0000_0000_0004);
      end
    join
    wait_cnt("stall", 32'd1, 32'd1);

    // Reset in the middle of a packet; remainder must be discarded
    out_rdy = 1'b0;
    src_q.push_back(0);
    send_word(0, 8'hFF, 64'h2222_0000_0000_0001);
    send_word(0, 8'h00, 64'h2222_0000_0000_0002);
    send_word(0, 8'h00, 64'h2222_0000_0000_0003);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk("midrst_sent2", 72'(sbq0.size()), 72'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_rdy = 1'b1;
    sbq0.delete(); sbq1.delete(); src_q.delete();
    @(negedge clk);
    chk("midrst_out_wr", 72'(out_wr), 72'd0);
    chk("midrst_in0_rdy", 72'(in0_rdy), 72'd1);
    chk("midrst_in1_rdy", 72'(in1_rdy), 72'd1);
    chk("midrst_cnt", {pkt_cnt0, pkt_cnt1}, 72'd0);
    @(posedge clk); #1;
    src_q.push_back(1);
    send_pkt(1, 1, 2, 8'hC0);
    wait_cnt("postrst", 32'd0, 32'd1);

    // Counter wrap on input 0
    @(posedge clk); #1;
    dut.pkt_cnt0 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap_preload", 72'(pkt_cnt0), 72'h0_FFFF_FFFF);
    @(posedge clk); #1;
    src_q.push_back(0);
    send_pkt(0, 1, 1, 8'h80);
    wait_cnt("wrap", 32'd0, 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
